// File: rtl/ctrl_pipe_stage_if.sv
// Control-pipeline bus: ID-side control word and hazard inputs in, per-stage strobes out.
// Latency: none, this is wiring only.
// Backpressure: none; stall/flush travel here as plain level signals.
// Ports: master = producer of id_* / stall / flush, slave = the pipeline stage itself.
interface ctrl_pipe_stage_if #(
    parameter int CTRL_W     = 12,
    parameter int REG_ADDR_W = 2,
    parameter int CNT_W      = 16
);
    logic [CTRL_W-1:0]     id_ctrl;
    logic                  id_valid;
    logic [REG_ADDR_W-1:0] id_rt;
    logic [REG_ADDR_W-1:0] id_rd;
    logic                  id_halt;
    logic                  id_wwd;
    logic                  stall;
    logic                  flush;

    logic [CTRL_W-1:0]     ex_ctrl;
    logic                  ex_valid;
    logic [REG_ADDR_W-1:0] ex_dest;
    logic                  ex_reg_write;
    logic                  ex_mem_read;

    logic                  mem_valid;
    logic                  mem_reg_write;
    logic                  mem_mem_read;
    logic                  mem_mem_write;
    logic [1:0]            mem_memtoreg;
    logic [REG_ADDR_W-1:0] mem_dest;

    logic                  wb_valid;
    logic                  wb_reg_write;
    logic                  wb_wwd;
    logic [1:0]            wb_memtoreg;
    logic [REG_ADDR_W-1:0] wb_dest;

    logic [CNT_W-1:0]      num_inst;
    logic                  halted;

    modport master (
        output id_ctrl, id_valid, id_rt, id_rd, id_halt, id_wwd, stall, flush,
        input  ex_ctrl, ex_valid, ex_dest, ex_reg_write, ex_mem_read,
        input  mem_valid, mem_reg_write, mem_mem_read, mem_mem_write, mem_memtoreg, mem_dest,
        input  wb_valid, wb_reg_write, wb_wwd, wb_memtoreg, wb_dest,
        input  num_inst, halted
    );

    modport slave (
        input  id_ctrl, id_valid, id_rt, id_rd, id_halt, id_wwd, stall, flush,
        output ex_ctrl, ex_valid, ex_dest, ex_reg_write, ex_mem_read,
        output mem_valid, mem_reg_write, mem_mem_read, mem_mem_write, mem_memtoreg, mem_dest,
        output wb_valid, wb_reg_write, wb_wwd, wb_memtoreg, wb_dest,
        output num_inst, halted
    );
endinterface

// File: rtl/ctrl_pipe_stage.sv
// Carries decoded control words ID->EX->MEM->WB, resolves dest reg, counts retirements, latches HLT.
// Latency: 1 cycle per stage (EX at +1, MEM at +2, WB at +3, retire count at +4).
// Backpressure: none; stall/flush/halt insert a bubble into EX, halt also bubbles MEM and WB.
// Ports: clk, reset (sync, active-high), bus (slave modport of ctrl_pipe_stage_if).
module ctrl_pipe_stage #(
    parameter int CTRL_W     = 12,
    parameter int REG_ADDR_W = 2,
    parameter int CNT_W      = 16
) (
    input  logic                clk,
    input  logic                reset,
    ctrl_pipe_stage_if.slave    bus
);
    // Control-word field positions.
    localparam int B_REG_WRITE = 11;
    localparam int B_MTR_HI    = 10;
    localparam int B_MTR_LO    = 9;
    localparam int B_MEM_READ  = 8;
    localparam int B_MEM_WRITE = 7;
    localparam int B_DST_HI    = 6;
    localparam int B_DST_LO    = 5;

    // ID/EX
    logic [CTRL_W-1:0]     ex_ctrl_q;
    logic                  ex_valid_q;
    logic [REG_ADDR_W-1:0] ex_rt_q;
    logic [REG_ADDR_W-1:0] ex_rd_q;
    logic                  ex_halt_q;
    logic                  ex_wwd_q;
    logic [REG_ADDR_W-1:0] ex_dest;

    // EX/MEM
    logic                  mem_valid_q;
    logic                  mem_reg_write_q;
    logic [1:0]            mem_memtoreg_q;
    logic                  mem_mem_read_q;
    logic                  mem_mem_write_q;
    logic [REG_ADDR_W-1:0] mem_dest_q;
    logic                  mem_halt_q;
    logic                  mem_wwd_q;

    // MEM/WB
    logic                  wb_valid_q;
    logic                  wb_reg_write_q;
    logic [1:0]            wb_memtoreg_q;
    logic [REG_ADDR_W-1:0] wb_dest_q;
    logic                  wb_halt_q;
    logic                  wb_wwd_q;

    logic [CNT_W-1:0]      num_q;
    logic                  halted_q;

    // Bubbling must start on the same edge HLT retires, otherwise the instruction
    // right behind it would reach WB one cycle before the sticky flag is visible.
    logic halt_now;
    assign halt_now = halted_q | (wb_valid_q & wb_halt_q);

    always_comb begin
        ex_dest = '0;
        case (ex_ctrl_q[B_DST_HI:B_DST_LO])
            2'b00:   ex_dest = ex_rt_q;
            2'b01:   ex_dest = ex_rd_q;
            2'b10:   ex_dest = REG_ADDR_W'(2);   // link register for JAL
            default: ex_dest = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_ctrl_q       <= '0;
            ex_valid_q      <= 1'b0;
            ex_rt_q         <= '0;
            ex_rd_q         <= '0;
            ex_halt_q       <= 1'b0;
            ex_wwd_q        <= 1'b0;
            mem_valid_q     <= 1'b0;
            mem_reg_write_q <= 1'b0;
            mem_memtoreg_q  <= '0;
            mem_mem_read_q  <= 1'b0;
            mem_mem_write_q <= 1'b0;
            mem_dest_q      <= '0;
            mem_halt_q      <= 1'b0;
            mem_wwd_q       <= 1'b0;
            wb_valid_q      <= 1'b0;
            wb_reg_write_q  <= 1'b0;
            wb_memtoreg_q   <= '0;
            wb_dest_q       <= '0;
            wb_halt_q       <= 1'b0;
            wb_wwd_q        <= 1'b0;
            num_q           <= '0;
            halted_q        <= 1'b0;
        end else begin
            if (bus.stall || bus.flush || halt_now) begin
                ex_ctrl_q  <= '0;
                ex_valid_q <= 1'b0;
                ex_rt_q    <= '0;
                ex_rd_q    <= '0;
                ex_halt_q  <= 1'b0;
                ex_wwd_q   <= 1'b0;
            end else begin
                ex_ctrl_q  <= bus.id_ctrl;
                ex_valid_q <= bus.id_valid;
                ex_rt_q    <= bus.id_rt;
                ex_rd_q    <= bus.id_rd;
                ex_halt_q  <= bus.id_halt;
                ex_wwd_q   <= bus.id_wwd;
            end

            if (halt_now) begin
                mem_valid_q     <= 1'b0;
                mem_reg_write_q <= 1'b0;
                mem_memtoreg_q  <= '0;
                mem_mem_read_q  <= 1'b0;
                mem_mem_write_q <= 1'b0;
                mem_dest_q      <= '0;
                mem_halt_q      <= 1'b0;
                mem_wwd_q       <= 1'b0;
                wb_valid_q      <= 1'b0;
                wb_reg_write_q  <= 1'b0;
                wb_memtoreg_q   <= '0;
                wb_dest_q       <= '0;
                wb_halt_q       <= 1'b0;
                wb_wwd_q        <= 1'b0;
            end else begin
                mem_valid_q     <= ex_valid_q;
                mem_reg_write_q <= ex_ctrl_q[B_REG_WRITE];
                mem_memtoreg_q  <= ex_ctrl_q[B_MTR_HI:B_MTR_LO];
                mem_mem_read_q  <= ex_ctrl_q[B_MEM_READ];
                mem_mem_write_q <= ex_ctrl_q[B_MEM_WRITE];
                mem_dest_q      <= ex_dest;
                mem_halt_q      <= ex_halt_q;
                mem_wwd_q       <= ex_wwd_q;
                wb_valid_q      <= mem_valid_q;
                wb_reg_write_q  <= mem_reg_write_q;
                wb_memtoreg_q   <= mem_memtoreg_q;
                wb_dest_q       <= mem_dest_q;
                wb_halt_q       <= mem_halt_q;
                wb_wwd_q        <= mem_wwd_q;
            end

            if (wb_valid_q && !halted_q) begin
                num_q <= num_q + CNT_W'(1);
            end
            if (wb_valid_q && wb_halt_q) begin
                halted_q <= 1'b1;
            end
        end
    end

    assign bus.ex_ctrl       = ex_ctrl_q;
    assign bus.ex_valid      = ex_valid_q;
    assign bus.ex_dest       = ex_dest;
    assign bus.ex_reg_write  = ex_ctrl_q[B_REG_WRITE] & ex_valid_q;
    assign bus.ex_mem_read   = ex_ctrl_q[B_MEM_READ] & ex_valid_q;

    assign bus.mem_valid     = mem_valid_q;
    assign bus.mem_reg_write = mem_reg_write_q & mem_valid_q;
    assign bus.mem_mem_read  = mem_mem_read_q & mem_valid_q;
    assign bus.mem_mem_write = mem_mem_write_q & mem_valid_q;
    assign bus.mem_memtoreg  = mem_memtoreg_q;
    assign bus.mem_dest      = mem_dest_q;

    assign bus.wb_valid      = wb_valid_q;
    assign bus.wb_reg_write  = wb_reg_write_q & wb_valid_q;
    assign bus.wb_wwd        = wb_wwd_q & wb_valid_q;
    assign bus.wb_memtoreg   = wb_memtoreg_q;
    assign bus.wb_dest       = wb_dest_q;

    assign bus.num_inst      = num_q;
    assign bus.halted        = halted_q;
endmodule
